// File: rtl/jtag_tdo_capture.sv
// jtag_tdo_capture: passive TAP monitor that packs shifted-out tdo bits into readback fifo words
module jtag_tdo_capture #(
    parameter int DATA_FIFO  = 8,
    parameter bit CAPTURE_IR = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tck,
    input  logic                 tms,
    input  logic                 tdo,
    input  logic                 full,
    output logic [DATA_FIFO-1:0] wdata,
    output logic                 wr,
    output logic                 overflow,
    output logic [3:0]           tap_state,
    output logic                 shift_active
);
    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } state_t;
    localparam int CW = $clog2(DATA_FIFO + 1);
    state_t               state, nxt;
    logic                 tck_r, tck_rr, tms_r, tdo_r, rise, cap, done, pend;
    logic [CW-1:0]        cnt, cnt_inc;
    logic [DATA_FIFO-1:0] word, word_nx;
    assign tap_state = state;
    assign wr        = pend & ~full;
    // TAP controller next state, taken only in tck rise cycles
    always_comb begin
        nxt = state;
        case (state)
            TLR:                  nxt = tms_r ? TLR    : RTI;
            RTI, UPD_DR, UPD_IR:  nxt = tms_r ? SEL_DR : RTI;
            SEL_DR:               nxt = tms_r ? SEL_IR : CAP_DR;
            SEL_IR:               nxt = tms_r ? TLR    : CAP_IR;
            CAP_DR, SH_DR:        nxt = tms_r ? EX1_DR : SH_DR;
            EX1_DR:               nxt = tms_r ? UPD_DR : PA_DR;
            PA_DR:                nxt = tms_r ? EX2_DR : PA_DR;
            EX2_DR:               nxt = tms_r ? UPD_DR : SH_DR;
            CAP_IR, SH_IR:        nxt = tms_r ? EX1_IR : SH_IR;
            EX1_IR:               nxt = tms_r ? UPD_IR : PA_IR;
            PA_IR:                nxt = tms_r ? EX2_IR : PA_IR;
            EX2_IR:               nxt = tms_r ? UPD_IR : SH_IR;
            default:              nxt = TLR;
        endcase
    end
    // capture decode: a word closes when full or when the shift state is left
    always_comb begin
        rise    = tck_r & ~tck_rr;
        cap     = rise && (state == SH_DR || (CAPTURE_IR && state == SH_IR));
        cnt_inc = cnt + CW'(1);
        word_nx = word | (DATA_FIFO'(tdo_r) << cnt);
        done    = cap && (cnt_inc == CW'(DATA_FIFO) || tms_r);
    end
    // input sampling, TAP tracking, word assembly and write/overflow handling
    always_ff @(posedge clk) begin
        if (rst) begin
            tck_r        <= 1'b0;
            tck_rr       <= 1'b0;
            tms_r        <= 1'b0;
            tdo_r        <= 1'b0;
            state        <= TLR;
            shift_active <= 1'b0;
            cnt          <= '0;
            word         <= '0;
            wdata        <= '0;
            pend         <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            tck_r  <= tck;
            tck_rr <= tck_r;
            tms_r  <= tms;
            tdo_r  <= tdo;
            pend   <= done;
            if (pend && full) overflow <= 1'b1;
            if (rise) begin
                state        <= nxt;
                shift_active <= nxt == SH_DR || (CAPTURE_IR && nxt == SH_IR);
            end
            if (cap) begin
                cnt  <= done ? '0 : cnt_inc;
                word <= done ? '0 : word_nx;
            end
            if (done) wdata <= word_nx;
        end
    end
endmodule
